// File: rtl/fuzz_response_misr_if.sv
// Bus bundle between a capture controller (master) and the response MISR (slave).
// Widths must match the parameters of the fuzz_response_misr instance it connects to.
interface fuzz_response_misr_if #(
  parameter int Y_WIDTH   = 233,
  parameter int SIG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic [CNT_WIDTH-1:0] num_samples;
  logic [SIG_WIDTH-1:0] expected_sig;
  logic                 y_valid;
  logic [Y_WIDTH-1:0]   y;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [SIG_WIDTH-1:0] signature;
  logic [CNT_WIDTH-1:0] sample_count;

  modport master (
    output start, num_samples, expected_sig, y_valid, y,
    input  busy, done, pass, signature, sample_count
  );

  modport slave (
    input  start, num_samples, expected_sig, y_valid, y,
    output busy, done, pass, signature, sample_count
  );
endinterface

// File: rtl/fuzz_response_misr.sv
// On-chip response checker: folds each qualified y sample into a MISR and,
// after a programmed number of samples, compares it with a golden signature.
module fuzz_response_misr #(
  parameter int                 Y_WIDTH   = 233,
  parameter int                 SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY    = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED    = 32'h00000000,
  parameter int                 CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  fuzz_response_misr_if.slave bus
);
  localparam int NCHUNK    = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PAD_WIDTH = NCHUNK * SIG_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t               state, state_next;
  logic [SIG_WIDTH-1:0] sig, exp_sig, fold, sig_step;
  logic [CNT_WIDTH-1:0] cnt, target, cnt_inc;
  logic [PAD_WIDTH-1:0] y_pad;
  logic                 pass_r;
  logic                 start_ok, absorb;

  assign y_pad = PAD_WIDTH'(bus.y);

  always_comb begin
    fold = '0;
    for (int i = 0; i < NCHUNK; i++)
      fold = fold ^ y_pad[i*SIG_WIDTH +: SIG_WIDTH];
  end

  assign sig_step = {sig[SIG_WIDTH-2:0], 1'b0}
                  ^ (sig[SIG_WIDTH-1] ? POLY : '0)
                  ^ fold;
  assign cnt_inc  = cnt + CNT_WIDTH'(1);

  // start is only honoured when no run is in flight
  assign start_ok = bus.start && (state == IDLE || state == DONE);
  assign absorb   = (state == RUN) && bus.y_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_ok) state_next = (bus.num_samples == '0) ? CHECK : RUN;
      RUN:        if (absorb && cnt_inc == target) state_next = CHECK;
      CHECK:      state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig     <= SEED;
      cnt     <= '0;
      target  <= '0;
      exp_sig <= '0;
      pass_r  <= 1'b0;
    end else if (start_ok) begin
      sig     <= SEED;
      cnt     <= '0;
      target  <= bus.num_samples;
      exp_sig <= bus.expected_sig;
      pass_r  <= 1'b0;
    end else if (absorb) begin
      sig     <= sig_step;
      cnt     <= cnt_inc;
    end else if (state == CHECK) begin
      pass_r  <= (sig == exp_sig);
    end
  end

  assign bus.busy         = (state == RUN) || (state == CHECK);
  assign bus.done         = (state == DONE);
  assign bus.pass         = pass_r;
  assign bus.signature    = sig;
  assign bus.sample_count = cnt;
endmodule

// File: tb/tb_fuzz_response_misr.sv
// Directed-vector bench for fuzz_response_misr: a scoreboard queue holds the
// hand-computed result of each run and a monitor checks it when done rises.
module tb_fuzz_response_misr;
  typedef struct {
    logic [31:0] sig;
    logic        pass;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic done_q = 1'b0;

  fuzz_response_misr_if #(.Y_WIDTH(233), .SIG_WIDTH(32), .CNT_WIDTH(16)) bus ();

  fuzz_response_misr #(
    .Y_WIDTH(233), .SIG_WIDTH(32), .POLY(32'h04C11DB7), .SEED(32'h0), .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // issue a start pulse; optionally record the run's expected outcome
  task automatic start_run(input logic [15:0] n, input logic [31:0] golden, input bit track,
                           input logic [31:0] e_sig, input logic e_pass, input logic [15:0] e_cnt);
    exp_t e;
    if (track) begin
      e.sig = e_sig; e.pass = e_pass; e.cnt = e_cnt;
      sb.push_back(e);
    end
    bus.start = 1'b1; bus.num_samples = n; bus.expected_sig = golden;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [232:0] yv, input logic v);
    bus.y = yv; bus.y_valid = v;
    @(posedge clk); #1;
    bus.y_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!bus.done && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_output(name, 64'(k), 64'd2);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done && !done_q) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending run");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("run_signature", 64'(bus.signature), 64'(e.sig));
        check_output("run_pass", 64'(bus.pass), 64'(e.pass));
        check_output("run_count", 64'(bus.sample_count), 64'(e.cnt));
      end
    end
    done_q = bus.done;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held;
    bus.start = 1'b0; bus.num_samples = '0; bus.expected_sig = '0;
    bus.y_valid = 1'b0; bus.y = '0;
    #12;
    check_output("reset_busy", 64'(bus.busy), 64'd0);
    check_output("reset_done", 64'(bus.done), 64'd0);
    check_output("reset_pass", 64'(bus.pass), 64'd0);
    check_output("reset_sig", 64'(bus.signature), 64'd0);
    check_output("reset_cnt", 64'(bus.sample_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single sample of 1 -> signature 1
    start_run(16'd1, 32'h1, 1, 32'h1, 1'b1, 16'd1);
    check_output("busy_in_run", 64'(bus.busy), 64'd1);
    apply_stimulus(233'h1, 1'b1);
    wait_done("latency_single");

    // y_valid in DONE is ignored
    held = bus.signature;
    apply_stimulus(233'hFFFF, 1'b1);
    check_output("done_ignores_y", 64'(bus.signature), 64'(held));

    // two samples of 1: shift(1)^1 = 3
    start_run(16'd2, 32'h3, 1, 32'h3, 1'b1, 16'd2);
    apply_stimulus(233'h1, 1'b1);
    apply_stimulus(233'h1, 1'b1);
    wait_done("latency_two");
    start_run(16'd2, 32'h4, 1, 32'h3, 1'b0, 16'd2);
    apply_stimulus(233'h1, 1'b1);
    apply_stimulus(233'h1, 1'b1);
    wait_done("latency_mismatch");

    // folding across chunks, including the partial top chunk
    start_run(16'd1, 32'h1, 1, 32'h1, 1'b1, 16'd1);
    apply_stimulus(233'd1 << 32, 1'b1);
    wait_done("latency_fold1");
    start_run(16'd1, 32'h0, 1, 32'h0, 1'b1, 16'd1);
    apply_stimulus((233'd1 << 32) | 233'd1, 1'b1);
    wait_done("latency_fold0");
    start_run(16'd1, 32'h100, 1, 32'h100, 1'b1, 16'd1);
    apply_stimulus(233'd1 << 232, 1'b1);
    wait_done("latency_fold_top");

    // feedback: MSB shifted out applies the polynomial
    start_run(16'd2, 32'h04C11DB7, 1, 32'h04C11DB7, 1'b1, 16'd2);
    apply_stimulus(233'h80000000, 1'b1);
    check_output("fb_first", 64'(bus.signature), 64'h80000000);
    apply_stimulus(233'h0, 1'b1);
    wait_done("latency_feedback");

    // gaps plus a stray start during RUN
    start_run(16'd2, 32'h3, 1, 32'h3, 1'b1, 16'd2);
    apply_stimulus(233'h1, 1'b1);
    check_output("gap_cnt0", 64'(bus.sample_count), 64'd1);
    bus.start = 1'b1; bus.num_samples = 16'd5; bus.expected_sig = 32'hDEAD;
    apply_stimulus(233'h1, 1'b0);
    bus.start = 1'b0;
    check_output("gap_cnt1", 64'(bus.sample_count), 64'd1);
    check_output("gap_busy", 64'(bus.busy), 64'd1);
    apply_stimulus(233'h1, 1'b0);
    check_output("gap_cnt2", 64'(bus.sample_count), 64'd1);
    apply_stimulus(233'h1, 1'b1);
    check_output("gap_cnt3", 64'(bus.sample_count), 64'd2);
    wait_done("latency_gap");

    // y on the start cycle is not absorbed
    bus.y = 233'hFF; bus.y_valid = 1'b1;
    start_run(16'd1, 32'h1, 1, 32'h1, 1'b1, 16'd1);
    apply_stimulus(233'h1, 1'b1);
    wait_done("latency_start_y");

    // zero-length runs
    start_run(16'd0, 32'h0, 1, 32'h0, 1'b1, 16'd0);
    wait_done("latency_zero_pass");
    start_run(16'd0, 32'h5, 1, 32'h0, 1'b0, 16'd0);
    wait_done("latency_zero_fail");

    // asynchronous reset after 3 of 10 samples
    start_run(16'd10, 32'h0, 0, 32'h0, 1'b0, 16'd0);
    apply_stimulus(233'h3, 1'b1);
    apply_stimulus(233'h5, 1'b1);
    apply_stimulus(233'h7, 1'b1);
    check_output("mid_cnt", 64'(bus.sample_count), 64'd3);
    #2 rst = 1'b1;
    #1;
    check_output("async_busy", 64'(bus.busy), 64'd0);
    check_output("async_done", 64'(bus.done), 64'd0);
    check_output("async_sig", 64'(bus.signature), 64'd0);
    check_output("async_cnt", 64'(bus.sample_count), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
